// File: rtl/pkt_af_pacer_if.sv
// Packet stream bundle around the almost-full pacer: upstream beat handshake,
// registered downstream beat and the downstream almost_full flag.
interface pkt_af_pacer_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_sop;
    logic                   in_eop;
    logic [EMPTY_WIDTH-1:0] in_empty;
    logic                   in_valid;
    logic                   in_ready;

    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_sop;
    logic                   out_eop;
    logic [EMPTY_WIDTH-1:0] out_empty;
    logic                   out_valid;
    logic                   out_almost_full;

    // master: the environment (packet source plus downstream sink)
    modport master (
        output in_data, in_sop, in_eop, in_empty, in_valid,
        input  in_ready,
        input  out_data, out_sop, out_eop, out_empty, out_valid,
        output out_almost_full
    );

    // slave: the pacer itself
    modport slave (
        input  in_data, in_sop, in_eop, in_empty, in_valid,
        output in_ready,
        output out_data, out_sop, out_eop, out_empty, out_valid,
        input  out_almost_full
    );
endinterface

// File: rtl/pkt_af_pacer.sv
// Almost-full packet pacer: gates a packet stream at packet boundaries with resume
// hysteresis and a burst limit. Define PKT_AF_PACER_STATS_EN for the stat counters.
module pkt_af_pacer #(
    parameter int DATA_WIDTH   = 512,
    parameter int EMPTY_WIDTH  = 6,
    parameter int RESUME_DELAY = 0,
    parameter int MAX_BURST    = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    pkt_af_pacer_if.slave       bus
`ifdef PKT_AF_PACER_STATS_EN
    ,
    output logic [31:0]         stat_pkt_cnt,
    output logic [31:0]         stat_pause_cyc
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    localparam logic [CNT_WIDTH-1:0] DLY_INIT  = CNT_WIDTH'((RESUME_DELAY > 0) ? RESUME_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH:0]   BURST_LIM = (CNT_WIDTH + 1)'(MAX_BURST);

    generate
        if (EMPTY_WIDTH != $clog2(DATA_WIDTH / 8)) begin : g_bad_empty
            $error("pkt_af_pacer: EMPTY_WIDTH must equal clog2(DATA_WIDTH/8)");
        end
    endgenerate

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] dly_cnt, dly_nxt;
    logic [CNT_WIDTH-1:0] burst_cnt, burst_nxt;
    logic [CNT_WIDTH-1:0] burst_sat;
    logic [CNT_WIDTH:0]   burst_inc;
    logic                 burst_hit;
    logic                 accept;
    logic                 eop_acc;

    // Ready is a pure state decode so almost_full never reaches it combinationally.
    assign bus.in_ready = (state == SEND);
    assign accept       = bus.in_valid & bus.in_ready;
    assign eop_acc      = accept & bus.in_eop;

    assign burst_inc = {1'b0, burst_cnt} + (CNT_WIDTH + 1)'(1);
    assign burst_hit = (MAX_BURST != 0) && (burst_inc == BURST_LIM);
    assign burst_sat = (&burst_cnt) ? burst_cnt : burst_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (!bus.out_almost_full) begin
                    if (RESUME_DELAY == 0) begin
                        state_nxt = SEND;
                        burst_nxt = '0;
                    end else begin
                        state_nxt = WAIT;
                        dly_nxt   = DLY_INIT;
                    end
                end
            end
            WAIT: begin
                if (bus.out_almost_full) begin
                    state_nxt = IDLE;
                end else if (dly_cnt == '0) begin
                    state_nxt = SEND;
                    burst_nxt = '0;
                end else begin
                    dly_nxt = dly_cnt - CNT_WIDTH'(1);
                end
            end
            SEND: begin
                // Exit only on an accepted eop, so a packet is never split.
                if (eop_acc) begin
                    burst_nxt = burst_sat;
                    if (bus.out_almost_full || burst_hit)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_empty <= '0;
        end else begin
            bus.out_valid <= accept;
            bus.out_sop   <= accept & bus.in_sop;
            bus.out_eop   <= eop_acc;
            bus.out_empty <= eop_acc ? bus.in_empty : '0;
        end
    end

    // Data is qualified by out_valid, so it is left unreset.
    always_ff @(posedge clk) begin
        bus.out_data <= bus.in_data;
    end

`ifdef PKT_AF_PACER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_cnt   <= '0;
            stat_pause_cyc <= '0;
        end else begin
            if (eop_acc)
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (state != SEND)
                stat_pause_cyc <= stat_pause_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_af_pacer.sv
// Directed bench for pkt_af_pacer: default, resume-delay and burst-limit instances
// share clk/rst; stat counters are checked when PKT_AF_PACER_STATS_EN is defined.
module tb_pkt_af_pacer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pkt_af_pacer_if #(.DATA_WIDTH(512), .EMPTY_WIDTH(6)) b0 ();
    pkt_af_pacer_if #(.DATA_WIDTH(32),  .EMPTY_WIDTH(2)) b1 ();
    pkt_af_pacer_if #(.DATA_WIDTH(32),  .EMPTY_WIDTH(2)) b2 ();

`ifdef PKT_AF_PACER_STATS_EN
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_pause_cyc;
`endif

    pkt_af_pacer d0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
`ifdef PKT_AF_PACER_STATS_EN
        ,
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_pause_cyc (stat_pause_cyc)
`endif
    );

    pkt_af_pacer #(.DATA_WIDTH(32), .EMPTY_WIDTH(2), .RESUME_DELAY(4)) d1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
`ifdef PKT_AF_PACER_STATS_EN
        ,
        .stat_pkt_cnt   (),
        .stat_pause_cyc ()
`endif
    );

    pkt_af_pacer #(.DATA_WIDTH(32), .EMPTY_WIDTH(2), .MAX_BURST(2)) d2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
`ifdef PKT_AF_PACER_STATS_EN
        ,
        .stat_pkt_cnt   (),
        .stat_pause_cyc ()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic [511:0] d, input logic s, input logic e,
                          input logic [5:0] emp, input logic v);
        b0.in_data  = d;
        b0.in_sop   = s;
        b0.in_eop   = e;
        b0.in_empty = emp;
        b0.in_valid = v;
    endtask

    initial begin
        logic [511:0] d;
        int n;
        bit rdy;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);
        b0.out_almost_full = 1'b0;
        b1.in_data = '0; b1.in_sop = 1'b0; b1.in_eop = 1'b0; b1.in_empty = '0; b1.in_valid = 1'b0;
        b1.out_almost_full = 1'b1;
        b2.in_data = '0; b2.in_sop = 1'b0; b2.in_eop = 1'b0; b2.in_empty = '0; b2.in_valid = 1'b0;
        b2.out_almost_full = 1'b1;
        repeat (3) tick();

        // reset state
        chk1("rst_ready", b0.in_ready, 1'b0);
        chk1("rst_valid", b0.out_valid, 1'b0);
        chk1("rst_sop", b0.out_sop, 1'b0);
        chk1("rst_eop", b0.out_eop, 1'b0);
        chkw("rst_empty", 512'(b0.out_empty), 512'(0));
        chk1("rst_ready_d1", b1.in_ready, 1'b0);
        chk1("rst_ready_d2", b2.in_ready, 1'b0);
`ifdef PKT_AF_PACER_STATS_EN
        chkw("rst_pkt_cnt", 512'(stat_pkt_cnt), 512'(0));
        chkw("rst_pause", 512'(stat_pause_cyc), 512'(0));
`endif

        // test 1: back-to-back 4-beat packets, af low
        rst = 1'b0;
        tick();
        chk1("t1_ready_on", b0.in_ready, 1'b1);
        chk1("t1_d1_held", b1.in_ready, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                d = 512'(32'hA500_0000 + p * 16 + b);
                drive0(d, b == 0, b == 3, 6'd7, 1'b1);
                tick();
                chk1("t1_valid", b0.out_valid, 1'b1);
                chkw("t1_data", b0.out_data, d);
                chk1("t1_sop", b0.out_sop, b == 0);
                chk1("t1_eop", b0.out_eop, b == 3);
                chkw("t1_empty", 512'(b0.out_empty), 512'((b == 3) ? 7 : 0));
                chk1("t1_ready", b0.in_ready, 1'b1);
            end
        end
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        chk1("t1_tail_valid", b0.out_valid, 1'b0);

        // test 2: af rises on beat 2 of a 5-beat packet
        for (int b = 0; b < 5; b++) begin
            d = 512'(32'hB000_0000 + b);
            b0.out_almost_full = (b >= 1);
            drive0(d, b == 0, b == 4, 6'd2, 1'b1);
            tick();
            chk1("t2_valid", b0.out_valid, 1'b1);
            chkw("t2_data", b0.out_data, d);
            chk1("t2_ready", b0.in_ready, b != 4);
        end
        chkw("t2_eop_empty", 512'(b0.out_empty), 512'(2));
        d = 512'(32'hB0B0_0001);
        drive0(d, 1'b1, 1'b1, 6'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t2_paused_valid", b0.out_valid, 1'b0);
            chk1("t2_paused_ready", b0.in_ready, 1'b0);
        end
        b0.out_almost_full = 1'b0;
        tick();
        chk1("t2_regrant_ready", b0.in_ready, 1'b1);
        chk1("t2_regrant_valid", b0.out_valid, 1'b0);
        tick();
        chk1("t2_resume_valid", b0.out_valid, 1'b1);
        chk1("t2_resume_sop", b0.out_sop, 1'b1);
        chkw("t2_resume_data", b0.out_data, d);
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();

        // test 5: reset mid-packet, then a clean packet
        for (int b = 0; b < 3; b++) begin
            drive0(512'(32'hC000_0000 + b), b == 0, 1'b0, 6'd0, 1'b1);
            tick();
            chk1("t5_pre_valid", b0.out_valid, 1'b1);
        end
        drive0(512'(32'hC000_0003), 1'b0, 1'b0, 6'd0, 1'b1);
        rst = 1'b1;
        tick();
        chk1("t5_rst_ready", b0.in_ready, 1'b0);
        chk1("t5_rst_valid", b0.out_valid, 1'b0);
        chk1("t5_rst_sop", b0.out_sop, 1'b0);
        rst = 1'b0;
        d = 512'(32'hD000_0000);
        drive0(d, 1'b1, 1'b0, 6'd0, 1'b1);
        tick();
        chk1("t5_idle_valid", b0.out_valid, 1'b0);
        chk1("t5_grant_ready", b0.in_ready, 1'b1);
        tick();
        chk1("t5_new_sop", b0.out_sop, 1'b1);
        chkw("t5_new_data0", b0.out_data, d);
        d = 512'(32'hD000_0001);
        drive0(d, 1'b0, 1'b1, 6'd3, 1'b1);
        tick();
        chk1("t5_new_eop", b0.out_eop, 1'b1);
        chkw("t5_new_data1", b0.out_data, d);
        chkw("t5_new_empty", 512'(b0.out_empty), 512'(3));
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);

        // test 3: RESUME_DELAY=4, short low pulse then a sustained low
        b1.out_almost_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t3_short_ready", b1.in_ready, 1'b0);
        end
        b1.out_almost_full = 1'b1;
        tick();
        chk1("t3_abort_ready", b1.in_ready, 1'b0);
        tick();
        chk1("t3_idle_ready", b1.in_ready, 1'b0);
        b1.out_almost_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t3_wait_ready", b1.in_ready, 1'b0);
        end
        tick();
        chk1("t3_send_ready", b1.in_ready, 1'b1);

        // test 4: MAX_BURST=2 with continuous single-beat packets
        b2.out_almost_full = 1'b0;
        tick();
        chk1("t4_grant", b2.in_ready, 1'b1);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            rdy = (i % 3) != 2;
            b2.in_data  = 32'(100 + n);
            b2.in_sop   = 1'b1;
            b2.in_eop   = 1'b1;
            b2.in_empty = 2'd1;
            b2.in_valid = 1'b1;
            tick();
            chk1("t4_valid", b2.out_valid, rdy);
            if (rdy) begin
                chkw("t4_data", 512'(b2.out_data), 512'(100 + n));
                n++;
            end
            chk1("t4_ready", b2.in_ready, ((i + 1) % 3) != 2);
        end
        b2.in_valid = 1'b0;

`ifdef PKT_AF_PACER_STATS_EN
        // test 6: 10 packets with 7 paused cycles after a fresh reset
        rst = 1'b1;
        tick();
        chkw("t6_clr_pkt", 512'(stat_pkt_cnt), 512'(0));
        chkw("t6_clr_pause", 512'(stat_pause_cyc), 512'(0));
        rst = 1'b0;
        b0.out_almost_full = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            b0.out_almost_full = (k == 5);
            drive0(512'(k), 1'b1, 1'b1, 6'd0, 1'b1);
            tick();
        end
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);
        repeat (5) tick();
        b0.out_almost_full = 1'b0;
        tick();
        for (int k = 6; k <= 10; k++) begin
            drive0(512'(k), 1'b1, 1'b1, 6'd0, 1'b1);
            tick();
        end
        drive0('0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        chkw("t6_pkt_cnt", 512'(stat_pkt_cnt), 512'(10));
        chkw("t6_pause", 512'(stat_pause_cyc), 512'(7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
